uart_oversampled_rx: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_oversampled_rx_if.sv | 40 ++++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_oversampled_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and default configuration for the receive engine.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } type_uart_rx_state_e;

endpackage

// File: rtl/uart_oversampled_rx_if.sv
// Bus-side signals of the oversampling UART receiver.
// Parity port pair is present only when UART_RX_PARITY_EN is defined.
interface uart_oversampled_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic                 rd_data_rx;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_complete;
  logic                 busy_rx;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_odd;
  logic                 parity_err;

  modport master (
    input  rd_data_rx, err_clr, parity_odd,
    output rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun, parity_err
  );
  modport slave (
    output rd_data_rx, err_clr, parity_odd,
    input  rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun, parity_err
  );
`else
  modport master (
    input  rd_data_rx, err_clr,
    output rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun
  );
  modport slave (
    output rd_data_rx, err_clr,
    input  rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun
  );
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic s_in,
  output logic line
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], s_in};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign line = sync_q[1];

endmodule

// File: rtl/uart_oversampled_rx.sv
// Oversampling UART receive engine: start validation, mid-bit sampling, holding register.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_oversampled_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic s_in,
  input  logic two_stop_bits,
  uart_oversampled_rx_if.master bus
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

  logic line;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .s_in (s_in),
    .line (line)
  );

  type_uart_rx_state_e  state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 armed_q, armed_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_complete_q, rx_complete_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 parity_err_q, parity_err_d;
  logic                 done, fe_set, ov_set, pe_set;

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    bcnt_d        = bcnt_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    armed_d       = armed_q;
    rx_valid_d    = rx_valid_q;
    rx_complete_d = 1'b0;
    frame_err_d   = frame_err_q;
    overrun_d     = overrun_q;
    parity_err_d  = parity_err_q;
    done          = 1'b0;
    fe_set        = 1'b0;
    ov_set        = 1'b0;
    pe_set        = 1'b0;

    // All sampling and counting advances only on oversample ticks.
    if (baud_tick) begin
      tcnt_d = tcnt_q + 1'b1;
      if (line) armed_d = 1'b1;
      case (state_q)
        RX_IDLE: begin
          if (!line && armed_q) begin
            state_d = RX_START;
            tcnt_d  = '0;
          end
        end
        RX_START: begin
          if (tcnt_q == T_MID) begin
            if (!line) begin
              state_d = RX_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (tcnt_q == T_END) begin
            shreg_d = {line, shreg_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) begin
              bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (tcnt_q == T_END) begin
            if (line != ((^shreg_q) ^ bus.parity_odd)) pe_set = 1'b1;
            state_d = RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (tcnt_q == T_END) begin
            if (!line) fe_set = 1'b1;
            if (two_stop_bits && (bcnt_q == '0)) begin
              bcnt_d = BW'(1);
            end else begin
              state_d = RX_IDLE;
              done    = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    // A read in the completion cycle frees the holding register for the new byte.
    if (bus.rd_data_rx) rx_valid_d = 1'b0;
    if (done) begin
      rx_complete_d = 1'b1;
      if (!rx_valid_q || bus.rd_data_rx) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        ov_set = 1'b1;
      end
    end

    if (bus.err_clr) begin
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
    end
    if (fe_set) frame_err_d  = 1'b1;
    if (ov_set) overrun_d    = 1'b1;
    if (pe_set) parity_err_d = 1'b1;

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      tcnt_q        <= '0;
      bcnt_q        <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      armed_q       <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_complete_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      bcnt_q        <= bcnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      armed_q       <= armed_d;
      rx_valid_q    <= rx_valid_d;
      rx_complete_q <= rx_complete_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_complete = rx_complete_q;
  assign bus.busy_rx     = busy_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q | parity_err_d;
`endif

endmodule
